// File: rtl/mux_scan_sel.sv
// Registered N:1 channel selector: direct (sel) or auto-scan with DWELL cycles per channel; optional MUX_SCAN_SEL_CHANNEL_MASK_EN adds ch_mask.
// Latency: 1 cycle from sampled inputs to out/out_valid/cur_ch/wrap/sel_err.
// Backpressure: none; en=0 freezes the counters and holds out/cur_ch with out_valid low.
module mux_scan_sel #(
    parameter int N     = 16,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N),
    localparam int DW   = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            en,
`ifdef MUX_SCAN_SEL_CHANNEL_MASK_EN
    input  logic [N-1:0]    ch_mask,
`endif
    output logic [W-1:0]    out,
    output logic            out_valid,
    output logic [SW-1:0]   cur_ch,
    output logic            wrap,
    output logic            sel_err
);

    logic [W-1:0]  r_out;
    logic          r_out_valid;
    logic [SW-1:0] r_cur_ch;
    logic          r_wrap;
    logic          r_sel_err;
    logic [SW-1:0] r_ch;
    logic [DW-1:0] r_dwell;
    logic          r_wrap_pend;
    logic          r_mode_q;

    logic          w_mode_chg;
    logic [SW-1:0] w_ch_cur;
    logic [DW-1:0] w_dwell_cur;
    logic          w_pend_cur;
    logic [W-1:0]  w_ch_dat;
    logic [W-1:0]  w_sel_dat;
    logic          w_sel_ok;
    logic          w_sel_masked;
    logic          w_masked_cur;
    logic          w_all_masked;
    logic [SW-1:0] w_ch_adv;
    logic          w_adv_wraps;

    logic [W-1:0]  w_out_nxt;
    logic          w_vld_nxt;
    logic [SW-1:0] w_cur_nxt;
    logic          w_wrap_nxt;
    logic          w_err_nxt;
    logic [SW-1:0] w_ch_nxt;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_pend_nxt;

    // A mode flip seen at this edge restarts the scan from channel 0 with no wrap.
    assign w_mode_chg  = (mode != r_mode_q);
    assign w_ch_cur    = w_mode_chg ? '0 : r_ch;
    assign w_dwell_cur = w_mode_chg ? '0 : r_dwell;
    assign w_pend_cur  = w_mode_chg ? 1'b0 : r_wrap_pend;
    assign w_sel_ok    = (int'(sel) < N);

    always_comb begin
        w_ch_dat  = '0;
        w_sel_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (w_ch_cur == SW'(k)) w_ch_dat  = in[k*W +: W];
            if (sel == SW'(k))      w_sel_dat = in[k*W +: W];
        end
    end

`ifdef MUX_SCAN_SEL_CHANNEL_MASK_EN
    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        w_ch_adv    = w_ch_cur;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(w_ch_cur) + off) % N;
            if (!found && !ch_mask[idx]) begin
                w_ch_adv = SW'(idx);
                found    = 1'b1;
            end
        end
        w_adv_wraps  = (w_ch_adv <= w_ch_cur);
        w_masked_cur = ch_mask[w_ch_cur];
        w_all_masked = &ch_mask;
        w_sel_masked = w_sel_ok && ch_mask[sel];
    end
`else
    assign w_ch_adv     = (w_ch_cur == SW'(N-1)) ? '0 : w_ch_cur + SW'(1);
    assign w_adv_wraps  = (w_ch_cur == SW'(N-1));
    assign w_masked_cur = 1'b0;
    assign w_all_masked = 1'b0;
    assign w_sel_masked = 1'b0;
`endif

    always_comb begin
        w_out_nxt   = r_out;
        w_vld_nxt   = 1'b0;
        w_cur_nxt   = r_cur_ch;
        w_wrap_nxt  = 1'b0;
        w_err_nxt   = r_sel_err;
        w_ch_nxt    = w_ch_cur;
        w_dwell_nxt = w_dwell_cur;
        w_pend_nxt  = w_pend_cur;
        if (en) begin
            if (!mode) begin
                w_ch_nxt    = '0;
                w_dwell_nxt = '0;
                w_pend_nxt  = 1'b0;
                if (!w_sel_ok) begin
                    w_out_nxt = '0;
                    w_cur_nxt = sel;
                    w_err_nxt = 1'b1;
                end else if (w_sel_masked) begin
                    w_err_nxt = 1'b0;
                end else begin
                    w_out_nxt = w_sel_dat;
                    w_cur_nxt = sel;
                    w_vld_nxt = 1'b1;
                    w_err_nxt = 1'b0;
                end
            end else begin
                w_err_nxt = 1'b0;
                if (w_all_masked) begin
                    w_ch_nxt = w_ch_cur;
                end else if (w_masked_cur) begin
                    // Current channel got masked: skip it now, dwell restarts on the new one.
                    w_ch_nxt    = w_ch_adv;
                    w_dwell_nxt = '0;
                    w_pend_nxt  = w_pend_cur | w_adv_wraps;
                end else begin
                    w_out_nxt  = w_ch_dat;
                    w_cur_nxt  = w_ch_cur;
                    w_vld_nxt  = 1'b1;
                    w_wrap_nxt = w_pend_cur;
                    if (w_dwell_cur == DW'(DWELL-1)) begin
                        w_dwell_nxt = '0;
                        w_ch_nxt    = w_ch_adv;
                        w_pend_nxt  = w_adv_wraps;
                    end else begin
                        w_dwell_nxt = w_dwell_cur + DW'(1);
                        w_pend_nxt  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_cur_ch    <= '0;
            r_wrap      <= 1'b0;
            r_sel_err   <= 1'b0;
            r_ch        <= '0;
            r_dwell     <= '0;
            r_wrap_pend <= 1'b0;
            r_mode_q    <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_vld_nxt;
            r_cur_ch    <= w_cur_nxt;
            r_wrap      <= w_wrap_nxt;
            r_sel_err   <= w_err_nxt;
            r_ch        <= w_ch_nxt;
            r_dwell     <= w_dwell_nxt;
            r_wrap_pend <= w_pend_nxt;
            r_mode_q    <= mode;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign cur_ch    = r_cur_ch;
    assign wrap      = r_wrap;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel (N=5, W=8, DWELL=3): the model counts enabled scan
// samples since restart and derives channel/wrap arithmetically.
module tb_mux_scan_sel;
    localparam int N     = 5;
    localparam int W     = 8;
    localparam int DWELL = 3;
    localparam int SW    = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           en;
    logic [W-1:0]   out;
    logic           out_valid;
    logic [SW-1:0]  cur_ch;
    logic           wrap;
    logic           sel_err;

    mux_scan_sel #(.N(N), .W(W), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .mode(mode), .en(en),
        .out(out), .out_valid(out_valid), .cur_ch(cur_ch), .wrap(wrap), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic [W-1:0]  dat;
        logic [SW-1:0] ch;
        logic          wrap;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int            m_k;
    logic          m_prev;
    logic [W-1:0]  m_out;
    logic [SW-1:0] m_cur;
    logic          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_prev = 1'b0; m_out = '0; m_cur = '0; m_err = 1'b0;
    endtask

    // Expected result of the edge that just sampled the current inputs.
    task automatic model_edge();
        exp_t e;
        int   ch;
        e = '0;
        if (mode !== m_prev) m_k = 0;
        m_prev = mode;
        if (!en) begin
            e.vld = 1'b0;
        end else if (!mode) begin
            m_k = 0;
            if (int'(sel) < N) begin
                m_out = in[int'(sel)*W +: W]; e.vld = 1'b1; m_err = 1'b0;
            end else begin
                m_out = '0; e.vld = 1'b0; m_err = 1'b1;
            end
            m_cur = sel;
        end else begin
            ch     = (m_k / DWELL) % N;
            e.wrap = (m_k != 0) && (m_k % (N*DWELL) == 0);
            m_out  = in[ch*W +: W];
            m_cur  = SW'(ch);
            m_err  = 1'b0;
            e.vld  = 1'b1;
            m_k++;
        end
        e.dat = m_out; e.ch = m_cur; e.err = m_err;
        q.push_back(e);
    endtask

    task automatic drive(input logic e, input logic m, input logic [SW-1:0] s, input logic [N*W-1:0] d);
        en = e; mode = m; sel = s; in = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_valid", 64'(out_valid), 64'(e.vld));
                check("out",       64'(out),       64'(e.dat));
                check("cur_ch",    64'(cur_ch),    64'(e.ch));
                check("wrap",      64'(wrap),      64'(e.wrap));
                check("sel_err",   64'(sel_err),   64'(e.err));
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time budget expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic check_zero(input string tag);
        check({tag, "_out"},       64'(out),       64'h0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_cur_ch"},    64'(cur_ch),    64'h0);
        check({tag, "_wrap"},      64'(wrap),      64'h0);
        check({tag, "_sel_err"},   64'(sel_err),   64'h0);
    endtask

    logic [N*W-1:0] fixed;
    logic [N*W-1:0] pat;
    logic [63:0]    r64;

    initial begin : stim
        rst_n = 1'b0; in = '0; sel = '0; mode = 1'b0; en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int s = 0; s < N; s++) begin
            pat = '0;
            pat[s*W +: W] = W'(8'hA0 + s);
            drive(1'b1, 1'b0, SW'(s), pat);
            drive(1'b1, 1'b0, SW'(s), ~pat);
        end
        for (int s = N; s < 8; s++) drive(1'b1, 1'b0, SW'(s), ~pat);
        drive(1'b1, 1'b0, SW'(4), {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});

        fixed = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 2*N*DWELL + 2; i++) drive(1'b1, 1'b1, '0, fixed);

        drive(1'b1, 1'b0, '0, fixed);
        for (int i = 0; i < 2*DWELL + 1; i++) drive(1'b1, 1'b1, '0, fixed);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0, fixed);
        for (int i = 0; i < N*DWELL + 2; i++) drive(1'b1, 1'b1, '0, fixed);

        drive(1'b0, 1'b0, '0, fixed);
        drive(1'b0, 1'b1, '0, fixed);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, '0, fixed);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            r64 = {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, mode, SW'($urandom_range(0, 7)), r64[N*W-1:0]);
        end

        drive(1'b1, 1'b0, '0, fixed);
        for (int i = 0; i < 3*DWELL + 1; i++) drive(1'b1, 1'b1, '0, fixed);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N*DWELL + 2; i++) drive(1'b1, 1'b1, '0, fixed);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
